// File: rtl/if_id_queue_pkg.sv
// Shared constants and types for the IF->ID instruction queue.
`default_nettype none

package if_id_queue_pkg;

  // Site-wide default queue depth; must be a power of two, >= 2.
  localparam int IF_ID_QUEUE_DEPTH = 2;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } queue_op_e;

  function automatic queue_op_e queue_op(input logic push, input logic pop);
    return queue_op_e'({push, pop});
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_queue.sv
// IF->ID instruction queue: DEPTH entries of {err, inst, pc} with valid/ready on both sides.
// Registered-only ready/valid keep fetch and decode timing paths fully decoupled.
`default_nettype none

module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = IF_ID_QUEUE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid_i,
  output logic                       if_ready_o,
  input  logic [ADDR_W-1:0]          if_pc_i,
  input  logic [INST_W-1:0]          if_inst_i,
  input  logic                       if_err_i,
  input  logic                       flush_i,
  output logic                       id_valid_o,
  input  logic                       id_ready_i,
  output logic [ADDR_W-1:0]          id_pc_o,
  output logic [INST_W-1:0]          id_inst_o,
  output logic                       id_err_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = ADDR_W + INST_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  queue_op_e          op;

  // Ready depends on registered occupancy only, so a full queue refuses a push even on a pop.
  assign if_ready_o = (count != CNT_W'(DEPTH));
  assign id_valid_o = (count != '0);

  assign push = if_valid_i & if_ready_o & ~flush_i;
  assign pop  = id_valid_o & id_ready_i & ~flush_i;
  assign op   = queue_op(push, pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case (op)
        OP_PUSH: count <= count + CNT_W'(1);
        OP_POP:  count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is intentionally left unreset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {if_err_i, if_inst_i, if_pc_i};
  end

  assign head      = mem[rd_ptr];
  assign id_pc_o   = id_valid_o ? head[ADDR_W-1:0] : '0;
  assign id_inst_o = id_valid_o ? head[ADDR_W +: INST_W] : '0;
  assign id_err_o  = id_valid_o & head[ENTRY_W-1];
  assign count_o   = count;

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed vector table plus multi-cycle sequences.
`default_nettype none

module tb_if_id_queue;
  import if_id_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DEPTH = 2 instance
  logic        if_valid, if_err, flush, id_ready, if_ready, id_valid, id_err;
  logic [31:0] if_pc, if_inst, id_pc, id_inst;
  logic [1:0]  count;

  // DEPTH = 4 and DEPTH = 8 instances share inputs
  logic        w_valid, w_err, w_ready;
  logic        w_flush = 1'b0;
  logic [31:0] w_pc, w_inst;
  logic        a_ready, a_valid, a_err, b_ready, b_valid, b_err;
  logic [31:0] a_pc, a_inst, b_pc, b_inst;
  logic [2:0]  a_count;
  logic [3:0]  b_count;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_ready_o(if_ready), .if_pc_i(if_pc),
    .if_inst_i(if_inst), .if_err_i(if_err), .flush_i(flush), .id_valid_o(id_valid),
    .id_ready_i(id_ready), .id_pc_o(id_pc), .id_inst_o(id_inst), .id_err_o(id_err),
    .count_o(count));

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .if_valid_i(w_valid), .if_ready_o(a_ready), .if_pc_i(w_pc),
    .if_inst_i(w_inst), .if_err_i(w_err), .flush_i(w_flush), .id_valid_o(a_valid),
    .id_ready_i(w_ready), .id_pc_o(a_pc), .id_inst_o(a_inst), .id_err_o(a_err),
    .count_o(a_count));

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .if_valid_i(w_valid), .if_ready_o(b_ready), .if_pc_i(w_pc),
    .if_inst_i(w_inst), .if_err_i(w_err), .flush_i(w_flush), .id_valid_o(b_valid),
    .id_ready_i(w_ready), .id_pc_o(b_pc), .id_inst_o(b_inst), .id_err_o(b_err),
    .count_o(b_count));

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        err;
    logic        ready;
    logic        flush;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_err;
    logic [1:0]  e_count;
    logic        e_ready;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t vecs[17];

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic err,
                              input logic rdy, input logic fl, input logic ev,
                              input logic [31:0] epc, input logic eerr,
                              input logic [1:0] ecnt, input logic erdy);
    vec_t t;
    t.valid = v; t.pc = pc; t.err = err; t.ready = rdy; t.flush = fl;
    t.e_valid = ev; t.e_pc = epc; t.e_err = eerr; t.e_count = ecnt; t.e_ready = erdy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [32:0] q[$];
  logic [32:0] qa[$];
  logic [32:0] qb[$];

  initial begin
    // Directed table: inputs applied before the edge, expectations sampled after it.
    vecs[0]  = mk(1, 32'h000, 0, 1, 0, 1, 32'h000, 0, 1, 1);
    vecs[1]  = mk(1, 32'h004, 0, 1, 0, 1, 32'h004, 0, 1, 1);
    vecs[2]  = mk(1, 32'h008, 0, 1, 0, 1, 32'h008, 0, 1, 1);
    vecs[3]  = mk(1, 32'h00C, 0, 1, 0, 1, 32'h00C, 0, 1, 1);
    vecs[4]  = mk(0, 32'h000, 0, 1, 0, 0, 32'h000, 0, 0, 1);
    vecs[5]  = mk(1, 32'h010, 0, 0, 0, 1, 32'h010, 0, 1, 1);
    vecs[6]  = mk(1, 32'h014, 0, 0, 0, 1, 32'h010, 0, 2, 0);
    vecs[7]  = mk(1, 32'h018, 0, 0, 0, 1, 32'h010, 0, 2, 0);
    vecs[8]  = mk(1, 32'h018, 0, 1, 0, 1, 32'h014, 0, 1, 1);
    vecs[9]  = mk(1, 32'h018, 0, 1, 0, 1, 32'h018, 0, 1, 1);
    vecs[10] = mk(0, 32'h000, 0, 1, 0, 0, 32'h000, 0, 0, 1);
    vecs[11] = mk(1, 32'h020, 1, 0, 0, 1, 32'h020, 1, 1, 1);
    vecs[12] = mk(1, 32'h024, 0, 1, 0, 1, 32'h024, 0, 1, 1);
    vecs[13] = mk(1, 32'h028, 0, 0, 0, 1, 32'h024, 0, 2, 0);
    vecs[14] = mk(1, 32'h02C, 1, 1, 1, 0, 32'h000, 0, 0, 1);
    vecs[15] = mk(1, 32'h100, 0, 0, 0, 1, 32'h100, 0, 1, 1);
    vecs[16] = mk(0, 32'h000, 0, 1, 0, 0, 32'h000, 0, 0, 1);

    if_valid = 0; if_err = 0; flush = 0; id_ready = 0; if_pc = '0; if_inst = '0;
    w_valid = 0; w_err = 0; w_ready = 0; w_pc = '0; w_inst = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", id_valid, 0);
    chk("rst_outs", {id_err, id_pc, id_inst}, 65'd0);
    rst = 1'b0;
    step();
    chk("rst_cnt_rdy", {count, if_ready}, {2'd0, 1'b1});

    for (int i = 0; i < 17; i++) begin
      if_valid = vecs[i].valid; if_pc = vecs[i].pc; if_inst = mk_inst(vecs[i].pc);
      if_err = vecs[i].err; id_ready = vecs[i].ready; flush = vecs[i].flush;
      step();
      chk($sformatf("v%0d_valid", i), id_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_pc", i), id_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_inst", i), id_inst, vecs[i].e_valid ? mk_inst(vecs[i].e_pc) : 32'd0);
      chk($sformatf("v%0d_err", i), id_err, vecs[i].e_err);
      chk($sformatf("v%0d_count", i), count, vecs[i].e_count);
      chk($sformatf("v%0d_ready", i), if_ready, vecs[i].e_ready);
    end
    flush = 0;

    // Asynchronous reset between edges while holding two entries.
    if_valid = 1; id_ready = 0; if_pc = 32'h200; if_inst = mk_inst(32'h200); step();
    if_pc = 32'h204; if_inst = mk_inst(32'h204); step();
    if_valid = 0;
    chk("pre_rst_count", count, 2);
    #3 rst = 1'b1;
    #1;
    chk("arst_outs", {id_valid, id_err, id_pc, id_inst}, 66'd0);
    chk("arst_count", count, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("arst_release", {if_ready, count}, {1'b1, 2'd0});

    // Random valid/ready traffic against a queue model, DEPTH = 2.
    begin
      int sent = 0;
      int cyc = 0;
      while (sent < 100 && cyc < 3000) begin
        logic m_push, m_pop;
        if_valid = 1'($urandom_range(0, 1)); id_ready = 1'($urandom_range(0, 1));
        if_err = 1'($urandom_range(0, 1));
        if_pc = 32'h1000 + 32'(sent) * 4; if_inst = mk_inst(if_pc);
        m_push = if_valid && q.size() < 2;
        m_pop = id_ready && q.size() > 0;
        step();
        cyc++;
        if (m_pop) void'(q.pop_front());
        if (m_push) begin q.push_back({if_err, if_pc}); sent++; end
        chk("rand_head", {id_valid, id_err, id_pc}, q.size() != 0 ? {1'b1, q[0]} : 34'd0);
        chk("rand_inst", id_inst, q.size() != 0 ? mk_inst(q[0][31:0]) : 32'd0);
        chk("rand_cnt", {if_ready, count}, {q.size() != 2, 2'(q.size())});
      end
      checks++;
      if (sent != 100) begin
        failures++;
        $display("FAIL rand_budget: got %0d entries expected 100", sent);
      end
      if_valid = 0; id_ready = 1;
      for (int k = 0; k < 4 && q.size() != 0; k++) begin
        step();
        void'(q.pop_front());
        chk("drain_head", {id_valid, id_err, id_pc}, q.size() != 0 ? {1'b1, q[0]} : 34'd0);
      end
      chk("drain_empty", {id_valid, count}, 3'd0);
    end

    // Fill/drain rounds on DEPTH 4 and 8 for repeated pointer wrap.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 16; k++) begin
        logic a_push, a_pop, b_push, b_pop;
        w_valid = (k < 8); w_ready = (k >= 8);
        w_pc = 32'h2000 + 32'(r * 8 + k) * 4; w_inst = mk_inst(w_pc); w_err = k[0];
        a_push = w_valid && qa.size() < 4; a_pop = w_ready && qa.size() > 0;
        b_push = w_valid && qb.size() < 8; b_pop = w_ready && qb.size() > 0;
        step();
        if (a_pop) void'(qa.pop_front());
        if (a_push) qa.push_back({w_err, w_pc});
        if (b_pop) void'(qb.pop_front());
        if (b_push) qb.push_back({w_err, w_pc});
        chk("d4_head", {a_valid, a_err, a_pc}, qa.size() != 0 ? {1'b1, qa[0]} : 34'd0);
        chk("d4_inst", a_inst, qa.size() != 0 ? mk_inst(qa[0][31:0]) : 32'd0);
        chk("d4_cnt", {a_ready, a_count}, {qa.size() != 4, 3'(qa.size())});
        chk("d8_head", {b_valid, b_err, b_pc}, qb.size() != 0 ? {1'b1, qb[0]} : 34'd0);
        chk("d8_inst", b_inst, qb.size() != 0 ? mk_inst(qb[0][31:0]) : 32'd0);
        chk("d8_cnt", {b_ready, b_count}, {qb.size() != 8, 4'(qb.size())});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
